// File: rtl/mac_tcdm_arbiter.sv
// mac_tcdm_arbiter
// Shares NP physical TCDM ports between NB_IN streamer requesters, each NP
// lanes wide. A requester is granted as a whole and stays locked until every
// lane it asked for has been accepted, so the lanes of one wide word are never
// interleaved with another requester. Ownership rotates round-robin.
// Responses come back one cycle after the grant. They are routed to the issuing
// requester through a per-lane tag.
// Optional feature macro: MAC_ARB_STALL_CNT_EN adds saturating per-requester
// stall counters on stall_cnt_o. Without it, stall_cnt_o is tied to zero.
module mac_tcdm_arbiter #(
    parameter int unsigned NB_IN = 2,
    parameter int unsigned NP    = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [NB_IN*NP-1:0]           in_req_i,
    input  logic [NB_IN*NP*AW-1:0]        in_add_i,
    input  logic [NB_IN*NP-1:0]           in_wen_i,
    input  logic [NB_IN*NP*(DW/8)-1:0]    in_be_i,
    input  logic [NB_IN*NP*DW-1:0]        in_data_i,
    output logic [NB_IN*NP-1:0]           in_gnt_o,
    output logic [NB_IN*NP*DW-1:0]        in_r_data_o,
    output logic [NB_IN*NP-1:0]           in_r_valid_o,
    output logic [NP-1:0]                 out_req_o,
    output logic [NP*AW-1:0]              out_add_o,
    output logic [NP-1:0]                 out_wen_o,
    output logic [NP*(DW/8)-1:0]          out_be_o,
    output logic [NP*DW-1:0]              out_data_o,
    input  logic [NP-1:0]                 out_gnt_i,
    input  logic [NP*DW-1:0]              out_r_data_i,
    input  logic [NP-1:0]                 out_r_valid_i,
    output logic [NB_IN*16-1:0]           stall_cnt_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = (NB_IN > 1) ? $clog2(NB_IN) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        rrPtr_q, rrPtr_d;
    logic [IW-1:0]        lockOwner_q, lockOwner_d;
    logic [NP-1:0]        doneMask_q, doneMask_d;
    logic [NP-1:0]        tagV_q, tagV_d;
    logic [NP-1:0][IW-1:0] tag_q, tag_d;

    logic                 flush;
    logic [NB_IN-1:0]     active;
    logic                 anyActive;
    logic [IW-1:0]        scanOwner;
    logic [IW-1:0]        owner;
    logic [NP-1:0]        ownerReq;
    logic [NP-1:0]        outReq;
    logic [NP-1:0]        laneGnt;

    assign flush = rst_i | clear_i;

    function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] idx);
        return (int'(idx) == int'(NB_IN) - 1) ? '0 : idx + IW'(1);
    endfunction

    // Find the first requester with any lane active, scanning upward from rrPtr_q.
    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        scanOwner = rrPtr_q;
        for (int r = 0; r < NB_IN; r++) begin
            active[r] = |in_req_i[r*NP +: NP];
        end
        anyActive = |active;
        for (int k = 0; k < NB_IN; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= int'(NB_IN)) begin
                idx = idx - int'(NB_IN);
            end
            if (!found && active[idx]) begin
                found     = 1'b1;
                scanOwner = IW'(idx);
            end
        end
    end

    // Pick the owner and work out which physical lanes are driven this cycle.
    always_comb begin
        owner    = (state_q == LOCKED) ? lockOwner_q : scanOwner;
        ownerReq = in_req_i[owner*NP +: NP];
        outReq   = '0;
        if (!flush) begin
            if (state_q == LOCKED) begin
                outReq = ownerReq & ~doneMask_q;
            end else if (anyActive) begin
                outReq = ownerReq;
            end
        end
        laneGnt = outReq & out_gnt_i;
    end

    // Route the owner's lanes to the physical ports and the physical grants back.
    always_comb begin
        out_req_o  = '0;
        out_add_o  = '0;
        out_wen_o  = '0;
        out_be_o   = '0;
        out_data_o = '0;
        in_gnt_o   = '0;
        for (int l = 0; l < NP; l++) begin
            if (outReq[l]) begin
                out_req_o[l]               = 1'b1;
                out_add_o[l*AW +: AW]      = in_add_i[(owner*NP+l)*AW +: AW];
                out_wen_o[l]               = in_wen_i[owner*NP+l];
                out_be_o[l*BW +: BW]       = in_be_i[(owner*NP+l)*BW +: BW];
                out_data_o[l*DW +: DW]     = in_data_i[(owner*NP+l)*DW +: DW];
                in_gnt_o[owner*NP+l]       = out_gnt_i[l];
            end
        end
    end

    // Steer each physical response to the requester recorded in that lane's tag.
    always_comb begin
        in_r_valid_o = '0;
        in_r_data_o  = '0;
        for (int l = 0; l < NP; l++) begin
            if (!flush && tagV_q[l] && out_r_valid_i[l]) begin
                in_r_valid_o[tag_q[l]*NP+l]            = 1'b1;
                in_r_data_o[(tag_q[l]*NP+l)*DW +: DW] = out_r_data_i[l*DW +: DW];
            end
        end
    end

    // Arbitration FSM next state: lock on a partial grant, rotate priority on completion.
    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        lockOwner_d = lockOwner_q;
        doneMask_d  = doneMask_q;
        case (state_q)
            IDLE: begin
                if (anyActive) begin
                    if ((ownerReq & ~out_gnt_i) != '0) begin
                        state_d     = LOCKED;
                        lockOwner_d = owner;
                        doneMask_d  = laneGnt;
                    end else begin
                        rrPtr_d = nextIdx(owner);
                    end
                end
            end
            LOCKED: begin
                doneMask_d = doneMask_q | laneGnt;
                if ((ownerReq & ~doneMask_d) == '0) begin
                    state_d    = IDLE;
                    rrPtr_d    = nextIdx(lockOwner_q);
                    doneMask_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Record which requester issued each granted lane, for next-cycle response routing.
    always_comb begin
        tagV_d = '0;
        tag_d  = tag_q;
        for (int l = 0; l < NP; l++) begin
            tagV_d[l] = laneGnt[l];
            if (laneGnt[l]) begin
                tag_d[l] = owner;
            end
        end
    end

    // State and tag registers; reset and soft clear both abort to an empty IDLE.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q     <= IDLE;
            rrPtr_q     <= '0;
            lockOwner_q <= '0;
            doneMask_q  <= '0;
            tagV_q      <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            lockOwner_q <= lockOwner_d;
            doneMask_q  <= doneMask_d;
            tagV_q      <= tagV_d;
            tag_q       <= tag_d;
        end
    end

`ifdef MAC_ARB_STALL_CNT_EN
    logic [NB_IN-1:0][15:0] stallCnt_q, stallCnt_d;

    // Count cycles a requester is asking but receives no grant on any lane.
    always_comb begin
        stallCnt_d = stallCnt_q;
        for (int r = 0; r < NB_IN; r++) begin
            if (active[r] && (in_gnt_o[r*NP +: NP] == '0) && (stallCnt_q[r] != 16'hFFFF)) begin
                stallCnt_d[r] = stallCnt_q[r] + 16'd1;
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mac_tcdm_arbiter.sv
// tb_mac_tcdm_arbiter
// Directed bench for mac_tcdm_arbiter with default parameters (2 requesters,
// 4 lanes). Expected values are written by hand from the intended behaviour.
// Stall counter expectations depend on MAC_ARB_STALL_CNT_EN.
module tb_mac_tcdm_arbiter;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic [7:0]    in_req_i;
    logic [255:0]  in_add_i;
    logic [7:0]    in_wen_i;
    logic [31:0]   in_be_i;
    logic [255:0]  in_data_i;
    logic [7:0]    in_gnt_o;
    logic [255:0]  in_r_data_o;
    logic [7:0]    in_r_valid_o;
    logic [3:0]    out_req_o;
    logic [127:0]  out_add_o;
    logic [3:0]    out_wen_o;
    logic [15:0]   out_be_o;
    logic [127:0]  out_data_o;
    logic [3:0]    out_gnt_i;
    logic [127:0]  out_r_data_i;
    logic [3:0]    out_r_valid_i;
    logic [31:0]   stall_cnt_o;

    int checks = 0;
    int errors = 0;

    mac_tcdm_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .in_req_i     (in_req_i),
        .in_add_i     (in_add_i),
        .in_wen_i     (in_wen_i),
        .in_be_i      (in_be_i),
        .in_data_i    (in_data_i),
        .in_gnt_o     (in_gnt_o),
        .in_r_data_o  (in_r_data_o),
        .in_r_valid_o (in_r_valid_o),
        .out_req_o    (out_req_o),
        .out_add_o    (out_add_o),
        .out_wen_o    (out_wen_o),
        .out_be_o     (out_be_o),
        .out_data_o   (out_data_o),
        .out_gnt_i    (out_gnt_i),
        .out_r_data_i (out_r_data_i),
        .out_r_valid_i(out_r_valid_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic [3:0] gnt, input logic [3:0] rvalid);
        in_req_i      = req;
        out_gnt_i     = gnt;
        out_r_valid_i = rvalid;
        @(negedge clk_i);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] stallExp(input logic [15:0] r1, input logic [15:0] r0);
`ifdef MAC_ARB_STALL_CNT_EN
        return {r1, r0};
`else
        return (r1 == r0) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        rst_i    = 1'b1;
        clear_i  = 1'b0;
        in_wen_i = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            in_add_i[32*i +: 32]  = 32'h1000_0000 + 32'(4*i);
            in_data_i[32*i +: 32] = 32'hD000_0000 + 32'(i);
            in_be_i[4*i +: 4]     = 4'(i + 1);
        end
        for (int l = 0; l < 4; l++) begin
            out_r_data_i[32*l +: 32] = 32'hA5A5_0000 + 32'(l);
        end

        // Reset held for two cycles with every lane requesting.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(8'hFF, 4'hF, 4'hF);
            checkOutput("reset out_req", out_req_o, 4'h0);
            checkOutput("reset in_gnt", in_gnt_o, 8'h00);
            checkOutput("reset in_r_valid", in_r_valid_o, 8'h00);
            nextCycle();
        end
        checkOutput("reset stall_cnt", stall_cnt_o, 32'd0);
        rst_i = 1'b0;
        applyStimulus(8'h00, 4'h0, 4'h0);
        checkOutput("idle out_req", out_req_o, 4'h0);
        nextCycle();

        // Fairness: both requesters on all lanes, full grants every cycle.
        applyStimulus(8'hFF, 4'hF, 4'h0);
        checkOutput("fair c0 gnt", in_gnt_o, 8'h0F);
        checkOutput("fair c0 add", out_add_o[31:0], 32'h1000_0000);
        nextCycle();
        applyStimulus(8'hFF, 4'hF, 4'h0);
        checkOutput("fair c1 gnt", in_gnt_o, 8'hF0);
        checkOutput("fair c1 add", out_add_o[31:0], 32'h1000_0010);
        checkOutput("fair c1 wen", out_wen_o, 4'hF);
        nextCycle();
        applyStimulus(8'hFF, 4'hF, 4'h0);
        checkOutput("fair c2 gnt", in_gnt_o, 8'h0F);
        nextCycle();
        applyStimulus(8'hFF, 4'hF, 4'h0);
        checkOutput("fair c3 gnt", in_gnt_o, 8'hF0);
        nextCycle();
        checkOutput("fair stall_cnt", stall_cnt_o, stallExp(16'd2, 16'd2));
        applyStimulus(8'h00, 4'h0, 4'h0);
        nextCycle();

        // Lock: r0 accepted on lanes 0-1, then lanes 2-3; r1 waits.
        applyStimulus(8'hFF, 4'b0011, 4'h0);
        checkOutput("lock c1 out_req", out_req_o, 4'hF);
        checkOutput("lock c1 gnt", in_gnt_o, 8'h03);
        nextCycle();
        applyStimulus(8'hFF, 4'b1100, 4'h0);
        checkOutput("lock c2 out_req", out_req_o, 4'b1100);
        checkOutput("lock c2 gnt", in_gnt_o, 8'h0C);
        nextCycle();
        applyStimulus(8'hFF, 4'hF, 4'h0);
        checkOutput("lock c3 gnt", in_gnt_o, 8'hF0);
        nextCycle();
        checkOutput("lock stall_cnt", stall_cnt_o, stallExp(16'd4, 16'd3));
        applyStimulus(8'h00, 4'h0, 4'h0);
        nextCycle();

        // Response routing: r0 read at t, r1 read at t+1.
        applyStimulus(8'hFF, 4'hF, 4'hF);
        checkOutput("route t gnt", in_gnt_o, 8'h0F);
        checkOutput("route t untagged rvalid", in_r_valid_o, 8'h00);
        nextCycle();
        applyStimulus(8'hF0, 4'hF, 4'hF);
        checkOutput("route t1 gnt", in_gnt_o, 8'hF0);
        checkOutput("route t1 rvalid", in_r_valid_o, 8'h0F);
        checkOutput("route t1 r0l0 data", in_r_data_o[31:0], 32'hA5A5_0000);
        checkOutput("route t1 r0l3 data", in_r_data_o[127:96], 32'hA5A5_0003);
        checkOutput("route t1 r1l0 data", in_r_data_o[159:128], 32'h0);
        nextCycle();
        applyStimulus(8'h00, 4'h0, 4'hF);
        checkOutput("route t2 rvalid", in_r_valid_o, 8'hF0);
        checkOutput("route t2 r1l0 data", in_r_data_o[159:128], 32'hA5A5_0000);
        checkOutput("route t2 r1l3 data", in_r_data_o[255:224], 32'hA5A5_0003);
        checkOutput("route t2 r0l0 data", in_r_data_o[31:0], 32'h0);
        nextCycle();
        applyStimulus(8'h00, 4'h0, 4'hF);
        checkOutput("route t3 stale rvalid", in_r_valid_o, 8'h00);
        nextCycle();

        // Clear while r1 is locked with only lane 0 done.
        applyStimulus(8'h0F, 4'hF, 4'h0);
        checkOutput("clear pre gnt", in_gnt_o, 8'h0F);
        nextCycle();
        applyStimulus(8'hF0, 4'b0001, 4'h0);
        checkOutput("clear lock gnt", in_gnt_o, 8'h10);
        nextCycle();
        clear_i = 1'b1;
        applyStimulus(8'hF0, 4'hF, 4'hF);
        checkOutput("clear out_req", out_req_o, 4'h0);
        checkOutput("clear in_gnt", in_gnt_o, 8'h00);
        checkOutput("clear rvalid", in_r_valid_o, 8'h00);
        nextCycle();
        clear_i = 1'b0;
        checkOutput("clear stall_cnt", stall_cnt_o, 32'd0);
        applyStimulus(8'hFF, 4'hF, 4'hF);
        checkOutput("post-clear owner r0", in_gnt_o, 8'h0F);
        checkOutput("post-clear dropped rvalid", in_r_valid_o, 8'h00);
        nextCycle();
        checkOutput("post-clear stall_cnt", stall_cnt_o, stallExp(16'd1, 16'd0));
        applyStimulus(8'h00, 4'h0, 4'h0);
        nextCycle();

        // Single requester: r1 writes for ten cycles, granted every cycle.
        in_wen_i = 8'h00;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(8'hF0, 4'hF, 4'h0);
            checkOutput($sformatf("single c%0d gnt", c), in_gnt_o, 8'hF0);
            if (c == 0) begin
                checkOutput("single data l0", out_data_o[31:0], 32'hD000_0004);
                checkOutput("single be l0", out_be_o[3:0], 4'h5);
                checkOutput("single wen", out_wen_o, 4'h0);
            end
            nextCycle();
        end
        checkOutput("single stall_cnt", stall_cnt_o, stallExp(16'd1, 16'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
